// File: rtl/pdm_decimator.sv
// Third-order CIC decimator turning a +1/-1 PDM bitstream into signed 8-bit samples.
// Optional output clamping is enabled by defining PDM_DECIM_SAT_EN; otherwise the output wraps.
module pdm_decimator #(
    parameter int DECIM_LOG2 = 5
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              tick_in,
    input  logic              pdm_in,
    output logic signed [7:0] sample_out,
    output logic              sample_valid_out
);

    localparam int W     = 3 * DECIM_LOG2 + 2;
    localparam int SHIFT = 3 * DECIM_LOG2 - 7;

    localparam logic signed [W-1:0] PLUS_ONE  = W'(1);
    localparam logic signed [W-1:0] MINUS_ONE = {W{1'b1}};
    localparam logic signed [W-1:0] POS_LIM   = W'(127);
    localparam logic signed [W-1:0] NEG_LIM   = W'(-128);

    logic signed [W-1:0]     integ1, integ2, integ3;
    logic signed [W-1:0]     snapshot;
    logic signed [W-1:0]     comb_dly1, comb_dly2, comb_dly3;
    logic signed [W-1:0]     comb1, comb2, comb3, scaled;
    logic signed [W-1:0]     pdm_step;
    logic signed [7:0]       sample_next;
    logic [DECIM_LOG2-1:0]   tick_cnt;
    logic                    pending;
    logic [1:0]              warmup_cnt;

    assign pdm_step = pdm_in ? PLUS_ONE : MINUS_ONE;

    // Integrators run as a registered cascade: each stage adds the previous stage's pre-edge value.
    // The last tick of a window also captures integrator 3 so the combs never see the next window.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            integ1   <= '0;
            integ2   <= '0;
            integ3   <= '0;
            snapshot <= '0;
            tick_cnt <= '0;
            pending  <= 1'b0;
        end else begin
            pending <= tick_in && (&tick_cnt);
            if (tick_in) begin
                integ1   <= integ1 + pdm_step;
                integ2   <= integ2 + integ1;
                integ3   <= integ3 + integ2;
                tick_cnt <= tick_cnt + 1'b1;
                if (&tick_cnt) begin
                    snapshot <= integ3 + integ2;
                end
            end
        end
    end

    always_comb begin
        comb1  = snapshot - comb_dly1;
        comb2  = comb1 - comb_dly2;
        comb3  = comb2 - comb_dly3;
        scaled = comb3 >>> SHIFT;
`ifdef PDM_DECIM_SAT_EN
        if (scaled > POS_LIM) begin
            sample_next = 8'sd127;
        end else if (scaled < NEG_LIM) begin
            sample_next = -8'sd128;
        end else begin
            sample_next = 8'(scaled);
        end
`else
        sample_next = 8'(scaled);
`endif
    end

    // Combs advance on every decimated sample, but the first three results after reset are
    // still filling the filter history and are withheld from the output.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            comb_dly1        <= '0;
            comb_dly2        <= '0;
            comb_dly3        <= '0;
            warmup_cnt       <= '0;
            sample_out       <= '0;
            sample_valid_out <= 1'b0;
        end else begin
            sample_valid_out <= 1'b0;
            if (pending) begin
                comb_dly1 <= snapshot;
                comb_dly2 <= comb1;
                comb_dly3 <= comb2;
                if (warmup_cnt != 2'd3) begin
                    warmup_cnt <= warmup_cnt + 2'd1;
                end else begin
                    sample_out       <= sample_next;
                    sample_valid_out <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pdm_decimator.sv
// Self-checking bench for pdm_decimator: table-driven steady-state patterns, timing and
// async-reset sequences, and a random stream checked against a CIC impulse-response model.
module tb_pdm_decimator;

    localparam int DECIM_LOG2 = 5;
    localparam int R          = 1 << DECIM_LOG2;
    localparam int SHIFT      = 3 * DECIM_LOG2 - 7;
    localparam int HLEN       = 3 * R - 2;

    logic              clk_in = 1'b0;
    logic              rst_in;
    logic              tick_in;
    logic              pdm_in;
    logic signed [7:0] sample_out;
    logic              sample_valid_out;

    pdm_decimator #(.DECIM_LOG2(DECIM_LOG2)) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .tick_in         (tick_in),
        .pdm_in          (pdm_in),
        .sample_out      (sample_out),
        .sample_valid_out(sample_valid_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        string      name;
        logic [3:0] pattern;
        bit         everyCycle;
        int         expected;
    } vec_t;

    int     checks = 0;
    int     errors = 0;
    int     xHist[$];
    longint h[HLEN];
    bit     expectNext;
    int     windowIdx;
    int     lastExpected;
    int     cycleCount;
    int     nValid;

    // Impulse response of three cascaded length-R moving sums.
    function automatic void buildImpulse();
        longint a[HLEN];
        longint b[HLEN];
        for (int i = 0; i < HLEN; i++) a[i] = (i < R) ? 1 : 0;
        repeat (2) begin
            for (int i = 0; i < HLEN; i++) b[i] = 0;
            for (int i = 0; i < HLEN; i++)
                for (int j = 0; j < R; j++)
                    if (i + j < HLEN) b[i + j] += a[i];
            a = b;
        end
        for (int i = 0; i < HLEN; i++) h[i] = a[i];
    endfunction

    // Output k (1-based) convolves the accepted +-1 inputs, with two ticks of cascade latency.
    function automatic int modelSample(int k);
        longint acc = 0;
        longint scaledVal;
        int     base = k * R - 3;
        int     v;
        for (int m = 0; m < HLEN; m++) begin
            int idx = base - m;
            if (idx >= 0 && idx < xHist.size()) acc += h[m] * longint'(xHist[idx]);
        end
        scaledVal = acc >>> SHIFT;
`ifdef PDM_DECIM_SAT_EN
        if (scaledVal > 127) v = 127;
        else if (scaledVal < -128) v = -128;
        else v = int'(scaledVal);
`else
        v = int'(scaledVal & 64'd255);
        if (v > 127) v -= 256;
`endif
        return v;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at t=%0t", name, actual, expected, $time);
        end
    endtask

    function automatic void clearModel();
        xHist.delete();
        expectNext   = 1'b0;
        windowIdx    = 0;
        lastExpected = 0;
        cycleCount   = 0;
    endfunction

    task automatic doReset();
        @(negedge clk_in);
        rst_in  = 1'b1;
        tick_in = 1'b0;
        pdm_in  = 1'b0;
        #1;
        checkOutput("reset_sample", int'(sample_out), 0);
        checkOutput("reset_valid", int'(sample_valid_out), 0);
        @(negedge clk_in);
        rst_in = 1'b0;
        clearModel();
    endtask

    // One clock: drive inputs, sample #1 after the edge, compare against the model.
    task automatic applyStimulus(input bit tick, input bit bitv);
        int expValid = 0;
        tick_in = tick;
        pdm_in  = bitv;
        @(posedge clk_in);
        #1;
        cycleCount++;
        if (expectNext && windowIdx > 3) begin
            expValid     = 1;
            lastExpected = modelSample(windowIdx);
        end
        checkOutput("valid", int'(sample_valid_out), expValid);
        checkOutput("sample", int'(sample_out), lastExpected);
        expectNext = 1'b0;
        if (tick) begin
            xHist.push_back(bitv ? 1 : -1);
            if (xHist.size() % R == 0) begin
                expectNext = 1'b1;
                windowIdx  = xHist.size() / R;
            end
        end
    endtask

    task automatic vecCycle(input bit tick, input bit bitv, input string name, input int expected);
        applyStimulus(tick, bitv);
        if (sample_valid_out) begin
            nValid++;
            checkOutput(name, int'(sample_out), expected);
        end
    endtask

    initial begin
        vec_t vecs[5];
        int   firstValid;
        int   prevValid;

        rst_in  = 1'b1;
        tick_in = 1'b0;
        pdm_in  = 1'b0;
        buildImpulse();
        clearModel();
        #1;
        checkOutput("power_on_sample", int'(sample_out), 0);
        checkOutput("power_on_valid", int'(sample_valid_out), 0);

`ifdef PDM_DECIM_SAT_EN
        vecs[0] = '{"all_ones", 4'b1111, 1'b0, 127};
`else
        vecs[0] = '{"all_ones", 4'b1111, 1'b0, -128};
`endif
        vecs[1] = '{"all_zeros", 4'b0000, 1'b1, -128};
        vecs[2] = '{"alternating", 4'b0101, 1'b0, 0};
        vecs[3] = '{"three_of_four", 4'b0111, 1'b1, 64};
        vecs[4] = '{"one_of_four", 4'b0001, 1'b1, -64};

        foreach (vecs[v]) begin
            doReset();
            nValid = 0;
            for (int t = 0; t < 7 * R; t++) begin
                vecCycle(1'b1, vecs[v].pattern[t % 4], vecs[v].name, vecs[v].expected);
                if (!vecs[v].everyCycle)
                    vecCycle(1'b0, 1'($urandom % 2), vecs[v].name, vecs[v].expected);
            end
            vecCycle(1'b0, 1'b0, vecs[v].name, vecs[v].expected);
            checkOutput({vecs[v].name, "_valid_count"}, nValid, 4);
        end

        // Tick every cycle: strobe spacing and position relative to the decimation edge.
        doReset();
        firstValid = -1;
        prevValid  = -1;
        for (int t = 0; t < 8 * R; t++) begin
            applyStimulus(1'b1, 1'($urandom % 2));
            if (sample_valid_out) begin
                if (firstValid < 0) firstValid = cycleCount;
                else checkOutput("valid_spacing", cycleCount - prevValid, R);
                prevValid = cycleCount;
            end
        end
        checkOutput("first_valid_cycle", firstValid, 4 * R + 1);

        // Asynchronous reset between edges in the middle of a window.
        doReset();
        for (int t = 0; t < 6 * R + R / 2; t++) applyStimulus(1'b1, (t % 4) != 3);
        checkOutput("pre_reset_sample", int'(sample_out), 64);
        #2;
        rst_in = 1'b1;
        #1;
        checkOutput("async_reset_sample", int'(sample_out), 0);
        checkOutput("async_reset_valid", int'(sample_valid_out), 0);
        @(negedge clk_in);
        rst_in = 1'b0;
        clearModel();
        nValid = 0;
        for (int t = 0; t < 6 * R; t++) vecCycle(1'b1, (t % 4) != 3, "post_reset", 64);
        vecCycle(1'b0, 1'b0, "post_reset", 64);
        checkOutput("post_reset_valid_count", nValid, 3);

        // Random ticks and bits against the model, with a random reset along the way.
        doReset();
        for (int c = 0; c < 3000; c++) begin
            if (c == 1700) doReset();
            applyStimulus(($urandom % 4) != 0, 1'($urandom % 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
